// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution datapath.
package conv_pkg;

  localparam int CONV_OUTPUT_DEFAULT = 32;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } collector_state_t;

  function automatic int out_size(input int image_size, input int kernel_size);
    return image_size - kernel_size + 1;
  endfunction

endpackage

// File: rtl/conv_fmap_buffer.sv
// Output feature-map store: one full column written per cycle, one element read.
// Each lane (output row) owns its own column-indexed array; read is a two-level mux.
module conv_fmap_buffer #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 26,
  parameter int IDX_W = 5
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_col,
  input  logic [SIZE*WIDTH-1:0]   wr_data,
  input  logic [IDX_W-1:0]        rd_row,
  input  logic [IDX_W-1:0]        rd_col,
  output logic [WIDTH-1:0]        rd_data
);

  logic [WIDTH-1:0] lane_word [SIZE];

  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_lane
      logic [WIDTH-1:0] row_mem [SIZE];

      always_ff @(posedge clk) begin
        if (wr_en) begin
          row_mem[wr_col] <= wr_data[gi*WIDTH +: WIDTH];
        end
      end

      assign lane_word[gi] = row_mem[rd_col];
    end
  endgenerate

  assign rd_data = lane_word[rd_row];

endmodule

// File: rtl/conv_output_collector.sv
// Collects OUT_SIZE columns of conv results into a map, then streams it row-major.
// Optional feature macro: COLLECT_RELU_EN (zero negative elements on the read path).
module conv_output_collector
  import conv_pkg::*;
#(
  parameter int CONV_OUTPUT = CONV_OUTPUT_DEFAULT,
  parameter int IMAGE_SIZE  = 28,
  parameter int KERNEL_SIZE = 3,
  localparam int OUT_SIZE   = out_size(IMAGE_SIZE, KERNEL_SIZE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic [OUT_SIZE*CONV_OUTPUT-1:0] in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CONV_OUTPUT-1:0]        out_data,
  output logic                          out_last,
  output logic                          busy,
  output logic                          overflow
);

  localparam int CNT_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OUT_SIZE - 1);

  collector_state_t state_reg, state_next;
  logic [CNT_W-1:0] col_cnt_reg, col_cnt_next;
  logic [CNT_W-1:0] rd_row_reg, rd_row_next;
  logic [CNT_W-1:0] rd_col_reg, rd_col_next;
  logic             overflow_reg, overflow_next;
  logic             wr_en;
  logic             at_last;
  logic [CONV_OUTPUT-1:0] rd_data;

  assign in_ready  = (state_reg == COLLECT);
  assign out_valid = (state_reg == DRAIN);
  assign at_last   = (rd_row_reg == LAST_IDX) && (rd_col_reg == LAST_IDX);
  assign out_last  = out_valid && at_last;
  assign busy      = out_valid || (col_cnt_reg != '0);
  assign overflow  = overflow_reg;
  assign wr_en     = in_valid && in_ready && !clear;

  always_comb begin
    state_next    = state_reg;
    col_cnt_next  = col_cnt_reg;
    rd_row_next   = rd_row_reg;
    rd_col_next   = rd_col_reg;
    overflow_next = overflow_reg;
    if (clear) begin
      state_next    = COLLECT;
      col_cnt_next  = '0;
      rd_row_next   = '0;
      rd_col_next   = '0;
      overflow_next = 1'b0;
    end else if (state_reg == COLLECT) begin
      if (in_valid) begin
        if (col_cnt_reg == LAST_IDX) begin
          col_cnt_next = '0;
          rd_row_next  = '0;
          rd_col_next  = '0;
          state_next   = DRAIN;
        end else begin
          col_cnt_next = col_cnt_reg + 1'b1;
        end
      end
    end else begin
      // A column arriving mid-drain is lost; flag it until cleared.
      if (in_valid) begin
        overflow_next = 1'b1;
      end
      if (out_ready) begin
        if (at_last) begin
          state_next  = COLLECT;
          rd_row_next = '0;
          rd_col_next = '0;
        end else if (rd_col_reg == LAST_IDX) begin
          rd_col_next = '0;
          rd_row_next = rd_row_reg + 1'b1;
        end else begin
          rd_col_next = rd_col_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= COLLECT;
      col_cnt_reg  <= '0;
      rd_row_reg   <= '0;
      rd_col_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      col_cnt_reg  <= col_cnt_next;
      rd_row_reg   <= rd_row_next;
      rd_col_reg   <= rd_col_next;
      overflow_reg <= overflow_next;
    end
  end

  conv_fmap_buffer #(
    .WIDTH (CONV_OUTPUT),
    .SIZE  (OUT_SIZE),
    .IDX_W (CNT_W)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_col  (col_cnt_reg),
    .wr_data (in_data),
    .rd_row  (rd_row_reg),
    .rd_col  (rd_col_reg),
    .rd_data (rd_data)
  );

`ifdef COLLECT_RELU_EN
  assign out_data = rd_data[CONV_OUTPUT-1] ? '0 : rd_data;
`else
  assign out_data = rd_data;
`endif

endmodule
